button_events: RTL and testbench
================================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter LONG_DELAY, default 12500000, cycles of hold before long-press (0.5 s at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 2500000, cycles between auto-repeat pulses once long-press is reached (0.1 s at 25 MHz).
REQ-003 SHALL have parameter CNT_W, default 24, counter width; must satisfy 2^CNT_W > max(LONG_DELAY, REPEAT_DELAY).
REQ-004 clock  input  1  system clock, all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clean  input  1  debounced, clock-synchronous button level, 1 = pressed.
REQ-007 enable  input  1  1 = event generation active.
REQ-008 press  output  1  one-cycle pulse on accepted press.
REQ-009 short_press  output  1  one-cycle pulse on release before long threshold.
REQ-010 long_press  output  1  one-cycle pulse when hold reaches LONG_DELAY.
REQ-011 repeat_tick  output  1  one-cycle pulse every REPEAT_DELAY cycles while held past long threshold.
REQ-012 release  output  1  one-cycle pulse on any release from PRESSED or LONG.
REQ-013 held  output  1  level, 1 while state is PRESSED or LONG.

Function
REQ-014 All outputs SHALL be registered; no combinational path from clean or enable to any output.
REQ-015 FSM SHALL have states WAIT_RELEASE, IDLE, PRESSED, LONG.
REQ-016 WAIT_RELEASE -> IDLE when enable=1 and clean=0; no pulses emitted in WAIT_RELEASE.
REQ-017 IDLE -> PRESSED when enable=1 and clean=1 sampled at edge T; press=1 during cycle T+1; count cleared to 0.
REQ-018 In PRESSED with clean=1, count SHALL increment each cycle; when count==LONG_DELAY-1, next state is LONG, count cleared, long_press=1 for one cycle; so long_press asserts exactly LONG_DELAY cycles after press.
REQ-019 In PRESSED with clean=0 -> IDLE, short_press=1 and release=1 in the same cycle; release SHALL take priority over a coincident count==LONG_DELAY-1 (short_press, no long_press).
REQ-020 In LONG with clean=1, count SHALL increment; at count==REPEAT_DELAY-1, repeat_tick=1 for one cycle and count cleared; first repeat_tick occurs REPEAT_DELAY cycles after long_press.
REQ-021 In LONG with clean=0 -> IDLE, release=1, no short_press; release SHALL win over a coincident repeat.
REQ-022 enable=0 in any state SHALL force WAIT_RELEASE at the next edge, clear count, and suppress all pulses that edge; held falls to 0 one cycle later.
REQ-023 At most one of press, short_press, long_press, repeat_tick SHALL be high in any cycle; release coincides only with short_press or alone.
REQ-024 Counter SHALL never wrap; it is cleared on every state transition.

Reset
REQ-025 reset_n low SHALL asynchronously set state=WAIT_RELEASE, count=0, all outputs 0.
REQ-026 Button held through reset SHALL produce no press until released and pressed again.
REQ-027 Reset assertion mid-hold SHALL discard the press with no release pulse.

Structure
REQ-028 State encoding and default delay constants SHALL live in shared package button_pkg.
REQ-029 Single module, no sub-modules; FSM and counter in one always block plus registered output decode.

Verification (bench uses LONG_DELAY=8, REPEAT_DELAY=4)
REQ-030 Reset released with clean=1 held 20 cycles -> no pulses, held=0; release then press -> press pulse one cycle after clean rises.
REQ-031 clean high 5 cycles then low -> press, then short_press+release together one cycle after clean falls, no long_press.
REQ-032 clean high 20 cycles -> press at T+1, long_press at T+9, repeat_tick at T+13 and T+17, release after fall, no short_press.
REQ-033 clean falls on the exact cycle count==7 -> short_press+release, long_press never asserts.
REQ-034 enable dropped while in LONG -> no further repeat_tick, no release, held=0 within 2 cycles; re-enable with clean=1 -> no press until clean cycles low then high.
REQ-035 reset_n pulsed low mid-PRESSED -> all outputs 0 immediately, no release pulse afterwards.

Source files
------------

// File: rtl/button_pkg.sv
// Shared state encoding and default timing constants for button event generation.
package button_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RELEASE = 2'd0,
        ST_IDLE         = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_LONG         = 2'd3
    } btn_state_t;

    localparam int LONG_DELAY_DEF   = 12500000;
    localparam int REPEAT_DELAY_DEF = 2500000;
    localparam int CNT_W_DEF        = 24;

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into press/short/long/repeat/release pulses and a held level.
// Latency: every output registered, one cycle after the sampling edge; no backpressure, pulses are fire-and-forget.
module button_events
    import button_pkg::*;
#(
    parameter int LONG_DELAY   = LONG_DELAY_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clean,
    input  logic enable,
    output logic press,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic released,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_WAIT_RELEASE;
            count       <= '0;
            press       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_tick <= 1'b0;
            released    <= 1'b0;
            held        <= 1'b0;
        end else begin
            press       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_tick <= 1'b0;
            released    <= 1'b0;

            if (!enable) begin
                // Disabling abandons any hold silently; a fresh release is required before the next press.
                state <= ST_WAIT_RELEASE;
                count <= '0;
                held  <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_RELEASE: begin
                        if (!clean) begin
                            state <= ST_IDLE;
                            count <= '0;
                        end
                    end
                    ST_IDLE: begin
                        if (clean) begin
                            state <= ST_PRESSED;
                            count <= '0;
                            press <= 1'b1;
                            held  <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        // Release is checked first so it wins over a coincident long threshold.
                        if (!clean) begin
                            state       <= ST_IDLE;
                            count       <= '0;
                            short_press <= 1'b1;
                            released    <= 1'b1;
                            held        <= 1'b0;
                        end else if (count == LONG_LAST) begin
                            state      <= ST_LONG;
                            count      <= '0;
                            long_press <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (!clean) begin
                            state    <= ST_IDLE;
                            count    <= '0;
                            released <= 1'b1;
                            held     <= 1'b0;
                        end else if (count == REPEAT_LAST) begin
                            count       <= '0;
                            repeat_tick <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_WAIT_RELEASE;
                        count <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench: each driven cycle pushes the expected output vector, popped and compared after the edge.
module tb_button_events;

    logic clock = 1'b0;
    logic reset_n;
    logic clean;
    logic enable;
    logic press, short_press, long_press, repeat_tick, released, held;

    // Vector layout: {held, released, repeat_tick, long_press, short_press, press}
    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] HELD  = 6'b100000;
    localparam logic [5:0] PRESS = 6'b100001;
    localparam logic [5:0] SREL  = 6'b010010;
    localparam logic [5:0] LONGP = 6'b100100;
    localparam logic [5:0] REP   = 6'b101000;
    localparam logic [5:0] REL   = 6'b010000;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    button_events #(
        .LONG_DELAY  (8),
        .REPEAT_DELAY(4),
        .CNT_W       (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clean      (clean),
        .enable     (enable),
        .press      (press),
        .short_press(short_press),
        .long_press (long_press),
        .repeat_tick(repeat_tick),
        .released   (released),
        .held       (held)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] outs();
        return {held, released, repeat_tick, long_press, short_press, press};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic c, input logic e, input logic [5:0] exp);
        @(negedge clock);
        clean  = c;
        enable = e;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            chk(tag, outs(), exp_q.pop_front());
        end
    endtask

    task automatic hold(input string tag, input logic c, input logic e, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) step(tag, c, e, exp);
    endtask

    // Press then keep clean high for n cycles total, checking press/long/repeat timing.
    task automatic press_for(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            if (k == 1)                           step(tag, 1'b1, 1'b1, PRESS);
            else if (k == 9)                      step(tag, 1'b1, 1'b1, LONGP);
            else if (k > 9 && ((k - 9) % 4) == 0) step(tag, 1'b1, 1'b1, REP);
            else                                  step(tag, 1'b1, 1'b1, HELD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clean   = 1'b1;
        enable  = 1'b1;
        #23;
        chk("reset_outs", outs(), NONE);
        @(negedge clock);
        reset_n = 1'b1;

        // Button held through reset: nothing until a release and fresh press.
        hold("held_thru_rst", 1'b1, 1'b1, 20, NONE);
        step("first_release", 1'b0, 1'b1, NONE);
        step("first_press", 1'b1, 1'b1, PRESS);
        step("first_short", 1'b0, 1'b1, SREL);
        hold("idle", 1'b0, 1'b1, 2, NONE);

        // Short press of five cycles.
        press_for("short5", 5);
        step("short5_rel", 1'b0, 1'b1, SREL);
        hold("idle", 1'b0, 1'b1, 2, NONE);

        // Long hold of twenty cycles; release coincides with a repeat and wins.
        press_for("long20", 20);
        step("long20_rel", 1'b0, 1'b1, REL);
        hold("idle", 1'b0, 1'b1, 2, NONE);

        // Release exactly on the long-threshold cycle.
        press_for("edge8", 8);
        step("edge8_rel", 1'b0, 1'b1, SREL);
        hold("idle", 1'b0, 1'b1, 3, NONE);

        // Disable while in LONG on the cycle a repeat would fire.
        press_for("dis_long", 12);
        step("dis_drop", 1'b1, 1'b0, NONE);
        hold("dis_hold", 1'b1, 1'b0, 4, NONE);
        hold("reen_held", 1'b1, 1'b1, 3, NONE);
        step("reen_rel", 1'b0, 1'b1, NONE);
        step("reen_press", 1'b1, 1'b1, PRESS);
        step("reen_short", 1'b0, 1'b1, SREL);
        hold("idle", 1'b0, 1'b1, 2, NONE);

        // Asynchronous reset mid-PRESSED discards the press with no release.
        press_for("mid_rst", 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", outs(), NONE);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        hold("post_rst_hold", 1'b1, 1'b1, 3, NONE);
        step("post_rst_rel", 1'b0, 1'b1, NONE);
        step("post_rst_press", 1'b1, 1'b1, PRESS);
        step("post_rst_short", 1'b0, 1'b1, SREL);
        step("idle", 1'b0, 1'b1, NONE);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover count=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
